if_id_buf: RTL
==============

Name: if_id_buf

Overview:
- 2-entry fetch buffer between the instruction fetch stage and decode.
- Captures each fetched {pc, inst} pair and presents it to decode through a valid/ready handshake.
- Decode can stall without losing fetched instructions.
- A branch/jump redirect flushes all buffered entries in one cycle.

Parameters:
ADDR_W, 8, width of the PC / instruction-memory address bus
INST_W, 32, instruction word width
NOP_INST, 0, value driven on out_inst when no valid entry is presented

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous reset, active-low
flush  input  1  discard all buffered entries (redirect from branch/jump resolution)
in_valid  input  1  fetch stage presents a valid {in_pc, in_inst}
in_ready  output  1  buffer can accept an entry this cycle
in_pc  input  ADDR_W  PC of the fetched instruction
in_inst  input  INST_W  fetched instruction word
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode accepts the head entry this cycle
out_pc  output  ADDR_W  PC of the head entry
out_inst  output  INST_W  instruction of the head entry
count  output  2  number of buffered entries, 0..2

Behaviour:
- Reset: rst_n=0 sampled at a rising edge sets:
  - count=0, read/write pointers=0, storage contents don't-care;
  - out_valid=0, out_pc=0, out_inst=NOP_INST, in_ready=1 (once rst_n=1).
- Reset overrides flush and both handshakes in the same cycle.
- Storage: 2-entry circular buffer.
  - 1-bit write pointer wp, 1-bit read pointer rp; both wrap 1->0.
  - count is held in a 2-bit register.
- Push = in_valid & in_ready; writes {in_pc, in_inst} at wp, then wp++.
- Pop = out_valid & out_ready; rp++.
- in_ready = (count != 2).
  - Registered-state only, no combinational path from out_ready.
  - Full and pop in the same cycle does NOT allow a push.
- out_valid = (count != 0). out_pc/out_inst = entry at rp when out_valid=1, else 0/NOP_INST.
- Count update:
  - push only: +1;
  - pop only: -1;
  - push and pop (only possible when count=1): unchanged; the new entry becomes head next cycle.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1 at the earliest.
- Ordering: strict FIFO; entries leave in push order.
- flush=1 at an edge sets count=0, wp=0, rp=0.
  - Any push or pop in that cycle is discarded and has no effect.
  - out_valid=0 from the next cycle.
  - flush has priority over push and pop.
- Back-to-back flushes are legal; the buffer stays empty.
- Underflow: pop with count=0 cannot occur (out_valid=0).
- Overflow: push with count=2 cannot occur (in_ready=0).
- Assertions must flag either case in simulation.
- in_pc/in_inst are ignored when in_valid=0. No X propagates to out_* when out_valid=0.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined:
  - When count=0 and flush=0, out_valid=in_valid and out_pc/out_inst=in_pc/in_inst combinationally, giving zero latency.
  - If out_ready=1 in that cycle, the entry is consumed directly and not stored; count stays 0.
  - If out_ready=0, the entry is stored normally.
  - flush=1 forces out_valid=0 in the same cycle.
- Undefined: bypass logic is absent; minimum latency is 1 cycle, as above.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 2 edges with in_valid=1, in_pc=0x10.
  - Required: out_valid=0, out_inst=NOP_INST, count=0, in_ready=1 after release.
- Streaming:
  - Stimulus: push pc 0x00..0x05 on consecutive cycles, out_ready=1 throughout.
  - Required: out_pc sequence 0x00..0x05 in order, each 1 cycle after push (0 with IFQ_BYPASS_EN); count never exceeds 1.
- Stall/full:
  - Stimulus: out_ready=0, push pc 0x20, 0x21, 0x22 back-to-back.
  - Required: count=2 and in_ready=0 after 2 pushes; 0x22 is held upstream.
  - Then: raise out_ready.
  - Required: outputs 0x20, 0x21, 0x22 in order with no loss or duplication.
- Wrap-around:
  - Stimulus: alternate push/pop for 7 entries starting from count=1.
  - Required: pointers wrap repeatedly; FIFO order preserved; count stays 1.
- Flush priority:
  - Stimulus: count=2 (0x30, 0x31); assert flush in the same cycle as in_valid=1 (pc 0x40) and out_ready=1.
  - Required: next cycle count=0, out_valid=0, and 0x40 never appears.
  - Then: next push 0x50 appears as head.
- Reset mid-operation:
  - Stimulus: rst_n=0 with count=2 and flush=1.
  - Required: count=0, pointers 0, out_pc=0; normal operation resumes on the first cycle after release.

Source files
------------

// File: rtl/if_id_buf.sv
// 2-entry fetch buffer between IF and ID. Latency is 1 cycle, or 0 when IFQ_BYPASS_EN is defined and the buffer is empty.
// Backpressure: in_ready drops while both entries are held and depends only on registered state. A redirect flush empties the buffer in one cycle.
module if_id_buf #(
    parameter int                ADDR_W   = 8,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [1:0]        count
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } ent_t;

    ent_t       r_mem [2];
    logic       r_wp;
    logic       r_rp;
    logic [1:0] r_count;

    ent_t w_head;
    logic w_byp;
    logic w_push;
    logic w_pop;
    logic w_thru;
    logic w_wr;
    logic w_rd;

    assign w_head = r_mem[r_rp];

`ifdef IFQ_BYPASS_EN
    assign w_byp = (r_count == 2'd0) & ~flush;
`else
    assign w_byp = 1'b0;
`endif

    assign in_ready = (r_count != 2'd2);
    assign count    = r_count;

    always_comb begin
        out_valid = w_byp ? in_valid : (r_count != 2'd0);
`ifdef IFQ_BYPASS_EN
        if (flush) begin
            out_valid = 1'b0;
        end
`endif
        out_pc   = '0;
        out_inst = NOP_INST;
        if (out_valid) begin
            out_pc   = w_byp ? in_pc   : w_head.pc;
            out_inst = w_byp ? in_inst : w_head.inst;
        end
    end

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;
    // A bypassed entry consumed in the same cycle never touches storage.
    assign w_thru = w_byp & w_push & out_ready;
    assign w_wr   = w_push & ~w_thru & ~flush;
    assign w_rd   = w_pop  & ~w_thru & ~flush;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= '{pc: in_pc, inst: in_inst};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_wr) begin
                r_wp <= ~r_wp;
            end
            if (w_rd) begin
                r_rp <= ~r_rp;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_rd && (r_count == 2'd0)));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_wr && !w_rd && (r_count == 2'd2)));
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        (r_count != 2'd3));

endmodule
